// File: rtl/example_scheduler.sv
// Training-example scheduler: issues example indices to the network, waits for each
// forward/backward pass, and counts epochs until EPOCHS full passes have completed.
module example_scheduler #(
    parameter int unsigned TOTAL_EXAMPLES = 4,
    parameter int unsigned EPOCHS         = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] example,
    output logic        ex_valid,
    input  logic        ex_ready,
    input  logic        pass_done,
    output logic [31:0] epoch,
    output logic        epoch_end,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] LAST_EX   = CNT_W'(TOTAL_EXAMPLES - 1);
    localparam logic [CNT_W-1:0] EPOCH_MAX = CNT_W'(EPOCHS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_example;
    logic [CNT_W-1:0] r_epoch;
    logic             r_epoch_end;
    logic             r_ex_valid;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_example_nxt;
    logic [CNT_W-1:0] w_epoch_nxt;
    logic             w_epoch_end_nxt;
    logic             w_ex_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_epoch_inc;

    assign w_epoch_inc = r_epoch + CNT_W'(1);

    // State and all outputs are registered together; flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_example   <= '0;
            r_epoch     <= '0;
            r_epoch_end <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_example   <= w_example_nxt;
            r_epoch     <= w_epoch_nxt;
            r_epoch_end <= w_epoch_end_nxt;
            r_ex_valid  <= w_ex_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_example_nxt   = r_example;
        w_epoch_nxt     = r_epoch;
        w_epoch_end_nxt = 1'b0;
        w_ex_valid_nxt  = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = ISSUE;
                    w_example_nxt = '0;
                    w_epoch_nxt   = '0;
                end
            end
            ISSUE: begin
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_example_nxt = '0;
                end else if (ex_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_example_nxt = '0;
                end else if (pass_done) begin
                    // Last example of the epoch wraps the index and bumps the epoch.
                    if (r_example >= LAST_EX) begin
                        w_example_nxt   = '0;
                        w_epoch_nxt     = w_epoch_inc;
                        w_epoch_end_nxt = 1'b1;
                        w_state_nxt     = (w_epoch_inc >= EPOCH_MAX) ? DONE : ISSUE;
                    end else begin
                        w_example_nxt = r_example + CNT_W'(1);
                        w_state_nxt   = ISSUE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    w_state_nxt   = IDLE;
                    w_example_nxt = '0;
                end else if (start) begin
                    w_state_nxt   = ISSUE;
                    w_example_nxt = '0;
                    w_epoch_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_example_nxt = '0;
            end
        endcase

        w_ex_valid_nxt = (w_state_nxt == ISSUE);
        w_busy_nxt     = (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
        w_done_nxt     = (w_state_nxt == DONE);
    end

    assign example   = r_example;
    assign ex_valid  = r_ex_valid;
    assign epoch     = r_epoch;
    assign epoch_end = r_epoch_end;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
